// File: rtl/apb_cmd_master_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_cmd_master_if
// Brief    : Command/response stream plus APB bus bundle for apb_cmd_master.
// Revision : 1.0 - initial release
// ============================================================================
interface apb_cmd_master_if #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32
);
  // core-side command channel
  logic                      req_valid_i;
  logic                      req_ready_o;
  logic [APB_ADDR_WIDTH-1:0] req_addr_i;
  logic                      req_we_i;
  logic [APB_DATA_WIDTH-1:0] req_wdata_i;

  // core-side response channel
  logic                      rsp_valid_o;
  logic                      rsp_ready_i;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_o;
  logic                      rsp_err_o;

  // APB initiator side
  logic [APB_ADDR_WIDTH-1:0] paddr_o;
  logic [APB_DATA_WIDTH-1:0] pwdata_o;
  logic                      pwrite_o;
  logic                      psel_o;
  logic                      penable_o;
  logic [APB_DATA_WIDTH-1:0] prdata_i;
  logic                      pready_i;
  logic                      pslverr_i;

  modport master (
    input  req_valid_i, req_addr_i, req_we_i, req_wdata_i, rsp_ready_i,
    input  prdata_i, pready_i, pslverr_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output paddr_o, pwdata_o, pwrite_o, psel_o, penable_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_we_i, req_wdata_i, rsp_ready_i,
    output prdata_i, pready_i, pslverr_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  paddr_o, pwdata_o, pwrite_o, psel_o, penable_o
  );
endinterface
`default_nettype wire

// File: rtl/apb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_cmd_master
// Brief    : Single-outstanding APB initiator driven by a valid/ready command
//            stream; returns read data / error on a valid/ready response.
//            Optional ACCESS wait-state timeout: define APB_MASTER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module apb_cmd_master #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  apb_cmd_master_if.master bus
);

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_check
    $error("apb_cmd_master: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                    r_state;
  logic                      r_psel;
  logic                      r_penable;
  logic                      r_pwrite;
  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic [APB_DATA_WIDTH-1:0] r_pwdata;
  logic                      r_rsp_valid;
  logic                      r_rsp_err;
  logic [APB_DATA_WIDTH-1:0] r_rsp_rdata;
  logic                      w_timeout;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int                 C_CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [C_CNT_W-1:0] C_TIMEOUT = C_CNT_W'(TIMEOUT_CYCLES);

  logic [C_CNT_W-1:0] r_wait_cnt;
  logic [C_CNT_W-1:0] w_wait_cnt_inc;

  // Abort on the wait cycle that would bring the count up to the limit.
  assign w_wait_cnt_inc = r_wait_cnt + 1'b1;
  assign w_timeout      = (w_wait_cnt_inc == C_TIMEOUT);
`else
  assign w_timeout      = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      r_wait_cnt  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid_i) begin
            r_paddr  <= bus.req_addr_i;
            r_pwrite <= bus.req_we_i;
            r_pwdata <= bus.req_wdata_i;
            r_psel   <= 1'b1;
            r_state  <= S_SETUP;
          end
        end

        S_SETUP: begin
          r_penable  <= 1'b1;
          r_state    <= S_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
        end

        S_ACCESS: begin
          // pready takes priority over a timeout reached in the same cycle
          if (bus.pready_i) begin
            r_rsp_rdata <= r_pwrite ? '0 : bus.prdata_i;
            r_rsp_err   <= bus.pslverr_i;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (w_timeout) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
`ifdef APB_MASTER_TIMEOUT_EN
            r_wait_cnt  <= w_wait_cnt_inc;
`endif
          end
        end

        S_RESP: begin
          if (bus.rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Ready depends on state only, so the response handshake cycle never accepts.
  assign bus.req_ready_o = (r_state == S_IDLE);
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_rdata_o = r_rsp_rdata;
  assign bus.rsp_err_o   = r_rsp_err;
  assign bus.paddr_o     = r_paddr;
  assign bus.pwdata_o    = r_pwdata;
  assign bus.pwrite_o    = r_pwrite;
  assign bus.psel_o      = r_psel;
  assign bus.penable_o   = r_penable;

endmodule
`default_nettype wire

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- APB initiator: turns a valid/ready command stream from a core-side agent (debug/DMA/test bridge) into single APB transfers.
- Drives an APB slave port such as the peripheral bus node input.
- Returns read data and error status on a valid/ready response channel.
- One outstanding transfer at a time.

Parameters:
APB_ADDR_WIDTH, 32, width of req_addr_i / paddr_o
APB_DATA_WIDTH, 32, width of data paths
TIMEOUT_CYCLES, 255, max consecutive ACCESS cycles with pready_i low before abort (only with APB_MASTER_TIMEOUT_EN); must be >= 1

Ports:
clk_i  input  1  single clock, all logic rising-edge
rst_i  input  1  reset, synchronous, active-high
req_valid_i  input  1  command valid
req_ready_o  output  1  command accepted when valid&ready
req_addr_i  input  APB_ADDR_WIDTH  target address
req_we_i  input  1  1=write, 0=read
req_wdata_i  input  APB_DATA_WIDTH  write data
rsp_valid_o  output  1  response valid
rsp_ready_i  input  1  response consumed when valid&ready
rsp_rdata_o  output  APB_DATA_WIDTH  read data (0 for writes/aborts)
rsp_err_o  output  1  PSLVERR or timeout
paddr_o  output  APB_ADDR_WIDTH  APB address
pwdata_o  output  APB_DATA_WIDTH  APB write data
pwrite_o  output  1  APB direction
psel_o  output  1  APB select
penable_o  output  1  APB enable
prdata_i  input  APB_DATA_WIDTH  APB read data
pready_i  input  1  APB ready
pslverr_i  input  1  APB slave error

Behaviour:
- Reset (rst_i=1 at edge): state IDLE; psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_err_o = 0; paddr_o, pwdata_o, rsp_rdata_o = 0; timeout counter = 0. req_ready_o = 1 once rst_i is low.
- Reset mid-transfer: bus is dropped at the same edge (psel_o=penable_o=0) and any pending response is discarded.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready_o=1 (combinational from state only).
  - On req_valid_i: register addr/we/wdata into paddr_o/pwrite_o/pwdata_o; go to SETUP.
- SETUP: psel_o=1, penable_o=0, for exactly one cycle; then ACCESS.
- ACCESS: psel_o=1, penable_o=1.
  - pready_i=1: capture rsp_rdata_o = pwrite_o ? 0 : prdata_i and rsp_err_o = pslverr_i; go to RESP.
  - pready_i=0: stay in ACCESS (wait states unbounded unless the optional feature is enabled).
- RESP: psel_o=penable_o=0, rsp_valid_o=1.
  - rsp_rdata_o and rsp_err_o hold stable until rsp_valid_o & rsp_ready_i.
  - On handshake: go to IDLE and clear rsp_valid_o.
- req_ready_o=0 in SETUP, ACCESS and RESP. A new command is never accepted in the response handshake cycle.
- paddr_o, pwrite_o and pwdata_o stay constant from SETUP through the end of ACCESS. They hold their last value in IDLE/RESP.
- pslverr_i is sampled only when pready_i=1 in ACCESS.
- Minimum latency: accept at edge T0 -> SETUP in T1 -> ACCESS in T2 (zero-wait pready) -> rsp_valid_o=1 in T3.
- Throughput: one transfer per 4 cycles when rsp_ready_i is tied high.

Optional Feature:
APB_MASTER_TIMEOUT_EN
- Defined:
  - Counter of width $clog2(TIMEOUT_CYCLES+1). Cleared on entry to ACCESS; increments each ACCESS cycle with pready_i=0.
  - When it reaches TIMEOUT_CYCLES, the transfer aborts: go to RESP with rsp_err_o=1 and rsp_rdata_o=0; psel_o/penable_o drop.
  - If pready_i=1 in the cycle the limit is reached, pready wins and the normal completion path is taken.
- Not defined: no counter; ACCESS waits for pready_i indefinitely; rsp_err_o reflects only pslverr_i.

Test Plan:
- Zero-wait write: addr 0x1A10_0000, wdata 0xDEAD_BEEF, pready=1 -> psel rises T1, penable T2, rsp_valid T3; rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: slave returns prdata 0x1234_5678 on the 4th ACCESS cycle -> addr stable throughout; rsp_rdata=0x1234_5678, rsp_valid 1 cycle after pready.
- Slave error: read with pready=1, pslverr=1 -> rsp_err=1. rsp_ready held low 5 cycles -> rsp_valid, rdata and err stay stable; req_ready stays 0.
- Back-to-back: req_valid held high for 3 commands, rsp_ready=1 -> exactly 3 SETUP phases, spaced 4 cycles apart, in order.
- Reset in ACCESS: rst_i=1 during a wait state -> next edge psel=penable=rsp_valid=0; after release req_ready=1 and no stale response appears.
- APB_MASTER_TIMEOUT_EN with TIMEOUT_CYCLES=4, pready stuck 0 -> abort after 4 ACCESS cycles, rsp_err=1, rdata=0. Repeat with pready=1 on the 4th cycle -> normal completion, err=pslverr.
